// File: rtl/rom_tick_streamer_pkg.sv
// Shared types and constants for the ROM tick streamer: controller states,
// output buffer depth and the buffered tick entry.
package rom_stream_pkg;

  localparam int BUF_DEPTH   = 2;
  localparam int TICK_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [TICK_DATA_W-1:0] data;
    logic                   last;
  } tick_entry_t;

endpackage

// File: rtl/rom_tick_streamer_if.sv
// Valid/ready price-tick stream between the ROM streamer (master) and the
// downstream strategy logic (slave).
interface rom_tick_streamer_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tick_data;
  logic                  tick_valid;
  logic                  tick_ready;
  logic                  tick_last;

  modport master (
    output tick_data,
    output tick_valid,
    output tick_last,
    input  tick_ready
  );

  modport slave (
    input  tick_data,
    input  tick_valid,
    input  tick_last,
    output tick_ready
  );

endinterface

// File: rtl/rom_tick_streamer_fifo.sv
// Two-entry FIFO holding ROM words (with their last flag) until the
// downstream consumer accepts them. Head entry is presented directly.
module tick_skid_fifo
  import rom_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  tick_entry_t din_i,
  output tick_entry_t head_o,
  output logic [1:0]  count_o
);

  tick_entry_t mem_q [BUF_DEPTH];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;

  // Storage, pointers and occupancy; flush drops contents without touching data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rom_tick_streamer.sv
// Walks ROM addresses 0..last_addr after a start pulse and streams each word
// as a price tick. A read is only issued when the 2-entry buffer is
// guaranteed room for it, so backpressure stalls the address instead of
// dropping data.
module rom_tick_streamer #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int BUF_DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  input  logic [ADDRESS_WIDTH-1:0] last_addr,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  rom_tick_streamer_if.master      tick,
  output logic                     busy,
  output logic                     done
);

  import rom_stream_pkg::*;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] rom_addr_q;
  logic [ADDRESS_WIDTH-1:0] last_q;
  logic                     loop_q;
  logic                     pend_q;
  logic                     pend_last_q;
  logic                     busy_q;
  logic                     done_q;

  logic [1:0]  count;
  tick_entry_t head;
  tick_entry_t din;
  logic        pop;
  logic        flush;
  logic [2:0]  fill;
  logic        issue;
  logic        issue_last;
  logic        drained;

  // Credit check: words already buffered or on the ROM output, minus the one
  // leaving now, must leave a free slot for the word issued this cycle.
  always_comb begin
    pop        = tick.tick_valid && tick.tick_ready;
    fill       = {1'b0, count} + {2'b00, pend_q} - {2'b00, pop};
    issue      = (state_q == RUN) && !abort && (fill < 3'(BUF_DEPTH));
    issue_last = (rom_addr_q == last_q);
    drained    = !pend_q && (fill == 3'd0);
    flush      = abort && (state_q != IDLE);
    din.data   = rom_dout;
    din.last   = pend_last_q;
  end

  tick_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (pend_q),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .count_o (count)
  );

  // Replay controller: address walk, pending-read tracking, busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      pend_q      <= issue;
      pend_last_q <= issue && issue_last;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            last_q     <= last_addr;
            loop_q     <= loop_en;
            rom_addr_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (issue) begin
            if (!issue_last) begin
              rom_addr_q <= rom_addr_q + ADDRESS_WIDTH'(1);
            end else if (loop_q) begin
              rom_addr_q <= '0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (drained) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr        = rom_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign tick.tick_valid = (count != 2'd0);
  assign tick.tick_data  = head.data;
  assign tick.tick_last  = head.last;

endmodule

// File: doc/rom_tick_streamer.md
Name: rom_tick_streamer

Overview:
- Read-side initiator for the stock-price ROM (1-cycle registered read, addr in / dout out).
- On a start pulse, walks ROM addresses 0..last_addr in order and presents each word as a price tick on a valid/ready stream to the downstream strategy logic.
- Absorbs the ROM read latency and downstream backpressure with a 2-entry buffer.
- Supports one-shot or continuous (loop) replay.

Parameters:
- ADDRESS_WIDTH, 16, ROM address width; must match the ROM instance.
- DATA_WIDTH, 8, ROM word / tick data width.
- BUF_DEPTH, 2, output buffer entries; fixed at 2, since other values are not supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a replay when idle.
- abort  input  1  one-cycle pulse; cancels the replay.
- loop_en  input  1  sampled at start; 1 = wrap to address 0 after last_addr.
- last_addr  input  ADDRESS_WIDTH  final address of a pass; sampled at start.
- rom_addr  output  ADDRESS_WIDTH  registered address to the ROM.
- rom_dout  input  DATA_WIDTH  ROM read data, valid the cycle after rom_addr was driven.
- tick_data  output  DATA_WIDTH  tick word.
- tick_valid  output  1  tick_data valid.
- tick_ready  input  1  downstream accept.
- tick_last  output  1  current tick came from last_addr.
- busy  output  1  high from the start edge until return to IDLE.
- done  output  1  one-cycle pulse when a non-loop replay completes.

Behaviour:
- Reset values (asynchronous, on rst high): rom_addr=0, tick_data=0, tick_valid=0, tick_last=0, busy=0, done=0. Reset also clears the FSM to IDLE, the buffer, and the pending-read flag.

States:
- IDLE: waits for start. On start && !abort: latch last_addr and loop_en, drive rom_addr=0 as the first issue, set busy, go to RUN.
- RUN: issues reads. After issuing latched last_addr:
  - loop=1: next issue is address 0; stay in RUN.
  - loop=0: go to DRAIN.
- DRAIN: no new issues. When the buffer is empty, no read is pending, and the final tick has handshaken: pulse done for 1 cycle, clear busy, go to IDLE.

Read and buffer rules:
- An "issue" means rom_addr holds address A during cycle c. The ROM registers it at the end of cycle c. rom_dout holds the word during c+1 and is written into the buffer at the end of c+1, together with a last flag (A == latched last_addr).
- The pending flag marks an issue made in the previous cycle.
- Issue is permitted only when occupancy + pending − pop_this_cycle < 2. The buffer can never overflow, and no read is ever dropped.
- Latency: start sampled at edge E0 → tick_valid high after edge E2, with data = ROM[0].
- Throughput: 1 tick/cycle while tick_ready is held high.
- Stream rules:
  - Pop occurs on tick_valid && tick_ready.
  - tick_data and tick_last are held stable while tick_valid && !tick_ready.
  - tick_valid = buffer not empty.
- rom_addr holds its last value when not issuing.
- Address increment is modulo 2^ADDRESS_WIDTH; last_addr = 2^ADDRESS_WIDTH−1 is legal.
- last_addr = 0: each pass is a single tick with tick_last=1.
- Simultaneous push and pop in the same cycle: occupancy unchanged, order preserved (FIFO).

Control corner cases:
- start while busy: ignored.
- abort while busy: next cycle flush the buffer, clear pending, tick_valid=0, busy=0, state IDLE, no done pulse. rom_addr keeps its value.
- abort and start in the same cycle: abort wins, so start is ignored.
- abort in IDLE: no effect.
- Loop mode: tick_last is asserted on every pass end; done never fires; only abort ends the replay.

Decomposition:
- Package rom_stream_pkg:
  - state enum (IDLE, RUN, DRAIN).
  - BUF_DEPTH constant.
  - Buffer-entry struct {data, last}.
- Sub-module tick_skid_fifo: 2-entry FIFO with push/pop, occupancy count, flush, head outputs.
- rom_tick_streamer contains the FSM, address counter, pending flag, and credit check.

Test Plan:
- ROM preloaded with data[i] = i[7:0] ^ 8'hA5; start, last_addr=3, loop_en=0, tick_ready=1 → ticks A5, A4, A7, A6 on 4 consecutive cycles, first valid 2 cycles after start; tick_last only on A6; done pulses once; busy falls the same cycle.
- Same run with tick_ready low for 5 cycles after the first valid → tick_data stays A5, never more than 2 buffered, rom_addr stalls; after release the sequence resumes with no loss or duplication.
- loop_en=1, last_addr=1, tick_ready=1 → A5, A4(last), A5, A4(last), ... for 10 ticks; done never asserted; abort → tick_valid=0 and busy=0 next cycle, no done.
- start pulsed again mid-run, and start+abort in the same cycle from IDLE → first ignored and the sequence is unaffected; second leaves the block idle.
- rst asserted asynchronously mid-RUN with tick_valid high → all outputs immediately at reset values; a fresh start after release replays from address 0.
- last_addr=0, loop_en=0, with random tick_ready → exactly one tick, A5 with tick_last=1, then done.
